// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the ADC128S022 serial reader.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned DATA_BITS    = 12;
  localparam int unsigned CH_BITS      = 3;
  localparam int unsigned ADDR_MSB_POS = 13;

  // Control word shifted out on DIN: channel address in bits 13..11, rest zero.
  function automatic logic [FRAME_BITS-1:0] ctrl_word(input logic [CH_BITS-1:0] ch);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[ADDR_MSB_POS -: CH_BITS] = ch;
    return w;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK half-period timer: while enabled, alternates fall/rise tick pulses every
// SCLK_DIV clk cycles, starting from the idle-high level.
module adc_sclk_gen #(
  parameter int unsigned SCLK_DIV = 13
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic fall_tick,
  output logic rise_tick
);

  logic [7:0] cnt_q;
  logic       level_q;
  logic       tick;

  assign tick      = en && (cnt_q == 8'(SCLK_DIV - 1));
  assign fall_tick = tick &  level_q;
  assign rise_tick = tick & ~level_q;

  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else if (tick) begin
      cnt_q   <= '0;
      level_q <= ~level_q;
    end else begin
      cnt_q   <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/adc_serial_reader.sv
// ADC128S022 frame initiator: addresses the next channel and reads the current
// conversion. Define ADC_SCAN_EN to free-run a round-robin scan of all channels.
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CH_BITS-1:0]   channel,
  output logic                 busy,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic [CH_BITS-1:0]   data_channel,
  output logic                 ADC_CS_N,
  output logic                 ADC_SCLK,
  output logic                 ADC_SADDR,
  input  logic                 ADC_SDAT
);

  state_t                 state_q;
  logic [CH_BITS-1:0]     ch_q;
  logic [CH_BITS-1:0]     prev_ch_q;
  logic [3:0]             bit_q;
  logic [FRAME_BITS-1:0]  shift_q;
  logic                   cs_n_q, sclk_q, saddr_q, busy_q, valid_q;
  logic [DATA_BITS-1:0]   data_q;
  logic [CH_BITS-1:0]     data_ch_q;

  logic                   fall_tick, rise_tick;
  logic                   go;
  logic [CH_BITS-1:0]     ch_d;
  logic [FRAME_BITS-1:0]  ctrl_w;
  logic [3:0]             addr_idx;

`ifdef ADC_SCAN_EN
  assign go   = 1'b1;
  assign ch_d = prev_ch_q + 3'd1;
`else
  assign go   = start;
  assign ch_d = channel;
`endif

  assign ctrl_w   = ctrl_word(ch_q);
  assign addr_idx = 4'(FRAME_BITS - 2) - bit_q;

  adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (state_q != IDLE),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      prev_ch_q <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      saddr_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      data_ch_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            ch_q    <= ch_d;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (fall_tick) begin
            sclk_q  <= 1'b0;
            saddr_q <= ctrl_w[FRAME_BITS-1];
            bit_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_tick) begin
            sclk_q  <= 1'b1;
            shift_q <= {shift_q[FRAME_BITS-2:0], ADC_SDAT};
          end else if (fall_tick) begin
            if (bit_q == 4'(FRAME_BITS - 1)) begin
              // End of the 16th high phase: SCLK stays high and the frame closes.
              cs_n_q    <= 1'b1;
              saddr_q   <= 1'b0;
              busy_q    <= 1'b0;
              valid_q   <= 1'b1;
              data_q    <= shift_q[DATA_BITS-1:0];
              data_ch_q <= prev_ch_q;
              prev_ch_q <= ch_q;
              state_q   <= IDLE;
            end else begin
              sclk_q  <= 1'b0;
              saddr_q <= ctrl_w[addr_idx];
              bit_q   <= bit_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign valid        = valid_q;
  assign data         = data_q;
  assign data_channel = data_ch_q;
  assign ADC_CS_N     = cs_n_q;
  assign ADC_SCLK     = sclk_q;
  assign ADC_SADDR    = saddr_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Scoreboard bench for adc_serial_reader with a behavioural ADC128S022 model.
module tb_adc_serial_reader;

  localparam int LAT = 1 + 33 * 13;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  channel;
  logic        busy, valid;
  logic [11:0] data;
  logic [2:0]  data_channel;
  logic        ADC_CS_N, ADC_SCLK, ADC_SADDR;
  logic        sdat = 1'b0;

  always #10 clk = ~clk;

  adc_serial_reader #(.SCLK_DIV(13)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .channel      (channel),
    .busy         (busy),
    .valid        (valid),
    .data         (data),
    .data_channel (data_channel),
    .ADC_CS_N     (ADC_CS_N),
    .ADC_SCLK     (ADC_SCLK),
    .ADC_SADDR    (ADC_SADDR),
    .ADC_SDAT     (sdat)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [11:0] d;
    logic [2:0]  ch;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [11:0] d, input logic [2:0] ch, input int at);
    exp_t e;
    e.d = d; e.ch = ch; e.at = at;
    sb.push_back(e);
  endtask

  // ADC model: per-channel results, DOUT changes after SCLK falls, address
  // bits captured at SCLK rises 3..5 select the next conversion.
  logic [11:0] val [8] = '{12'hA5C, 12'h123, 12'h456, 12'h789,
                           12'hABC, 12'hDEF, 12'h0F0, 12'hFFF};
  logic [2:0]  conv_ch = 3'd0;
  logic [15:0] word = '0;
  logic [2:0]  ch_cap = '0, last_cap = '0;
  int          rises = 0, falls = 0, last_rises = 0, hi_run = 0;
  int          hi_runs[$];
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;

  initial forever begin
    @(negedge clk);
    if (prev_cs === 1'b1 && ADC_CS_N === 1'b0) begin
      word   = {4'b0000, val[conv_ch]};
      rises  = 0;
      falls  = 0;
      ch_cap = '0;
      hi_runs.push_back(hi_run);
      hi_run = 0;
    end
    if (prev_cs === 1'b0 && ADC_CS_N === 1'b1) begin
      last_rises = rises;
      last_cap   = ch_cap;
      if (rises >= 5) conv_ch = ch_cap;
    end
    if (ADC_CS_N === 1'b0 && prev_sclk === 1'b0 && ADC_SCLK === 1'b1) begin
      rises++;
      if (rises >= 3 && rises <= 5) ch_cap[5 - rises] = ADC_SADDR;
    end
    if (ADC_CS_N === 1'b0 && prev_sclk === 1'b1 && ADC_SCLK === 1'b0) begin
      falls++;
      if (falls <= 16) sdat = word[16 - falls];
    end
    if (ADC_CS_N === 1'b1) hi_run++;
    prev_cs   = ADC_CS_N;
    prev_sclk = ADC_SCLK;
  end

  // Monitor: every valid pulse pops one expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n === 1'b1 && valid === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(data_channel), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("data", 32'(data), 32'(e.d));
        check("data_channel", 32'(data_channel), 32'(e.ch));
        if (e.at >= 0) check("valid_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic wait_done(input int limit);
    int n = 0;
    while (!(sb.size() == 0 && busy === 1'b0 && ADC_CS_N === 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_in_budget", 32'(n < limit), 32'd1);
  endtask

  int acc, v0, n;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    channel = 3'd0;
    repeat (5) @(negedge clk);
    check("rst_cs_n",  32'(ADC_CS_N),  32'd1);
    check("rst_sclk",  32'(ADC_SCLK),  32'd1);
    check("rst_saddr", 32'(ADC_SADDR), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_valid", 32'(valid),     32'd0);
    check("rst_data",  32'(data),      32'd0);
    check("rst_dch",   32'(data_channel), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef ADC_SCAN_EN
    for (int i = 0; i < 9; i++) push(val[i % 8], 3'(i % 8), -1);
    wait_done(9 * LAT + 100);
`else
    // Single frame addressing ch3; ADC reports its power-up ch0 conversion.
    channel = 3'd3; start = 1'b1; acc = cyc;
    push(12'hA5C, 3'd0, acc + LAT);
    @(negedge clk); start = 1'b0;
    wait_done(LAT + 50);
    check("saddr_ch_bits", 32'(last_cap), 32'd3);
    check("sclk_rises", 32'(last_rises), 32'd16);

    // Back-to-back ch5 then ch2, second start accepted in the valid cycle.
    @(negedge clk);
    channel = 3'd5; start = 1'b1; acc = cyc;
    push(12'h789, 3'd3, acc + LAT);
    push(12'hDEF, 3'd5, acc + 2 * LAT);
    @(negedge clk); channel = 3'd2;
    n = 0;
    while (valid !== 1'b1 && n < LAT + 50) begin @(negedge clk); n++; end
    check("b2b_valid_seen", 32'(n < LAT + 50), 32'd1);
    @(negedge clk); start = 1'b0;
    wait_done(LAT + 50);

    // Start held for 1000 cycles: two valids, CS_N high one cycle between frames.
    @(negedge clk);
    channel = 3'd0; start = 1'b1; acc = cyc; v0 = valid_cnt;
    hi_runs.delete();
    push(12'h456, 3'd2, acc + LAT);
    push(12'hA5C, 3'd0, acc + 2 * LAT);
    push(12'hA5C, 3'd0, acc + 3 * LAT);
    repeat (1000) @(negedge clk);
    start = 1'b0;
    check("held_valids", 32'(valid_cnt - v0), 32'd2);
    check("held_cs_falls", 32'(hi_runs.size()), 32'd3);
    if (hi_runs.size() == 3) begin
      check("cs_high_gap1", 32'(hi_runs[1]), 32'd1);
      check("cs_high_gap2", 32'(hi_runs[2]), 32'd1);
    end
    wait_done(LAT + 50);

    // Reset after the 7th rising SCLK edge of a ch6 frame: discarded, no valid.
    @(negedge clk);
    channel = 3'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (rises < 7 && n < LAT) begin @(negedge clk); n++; end
    check("mid_rise7_seen", 32'(n < LAT), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_cs_n",  32'(ADC_CS_N), 32'd1);
    check("mid_sclk",  32'(ADC_SCLK), 32'd1);
    check("mid_busy",  32'(busy),     32'd0);
    check("mid_valid", 32'(valid),    32'd0);
    check("mid_data",  32'(data),     32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    channel = 3'd1; start = 1'b1; acc = cyc;
    push(12'h0F0, 3'd0, acc + LAT);
    @(negedge clk); start = 1'b0;
    wait_done(LAT + 50);
    @(negedge clk);
    channel = 3'd0; start = 1'b1; acc = cyc;
    push(12'h123, 3'd1, acc + LAT);
    @(negedge clk); start = 1'b0;
    wait_done(LAT + 50);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
# adc_serial_reader

Initiator/reader for the on-board ADC128S022 serial ADC on the ADC_CS_N/ADC_SCLK/ADC_SADDR/ADC_SDAT pins of the DE0-Nano top level. On each accepted request it runs one 16-bit frame:

- drives the channel address for the next conversion;
- shifts in the 12-bit result of the current conversion;
- presents the result with a one-cycle valid pulse, tagged with the channel it belongs to.

It sits between the 50 MHz fabric logic and the ADC pins, alongside the DRAM interface and clock-divider blocks.

## Interface
- SCLK_DIV, 13: clk cycles per SCLK half-period; legal range 2..255. Default gives 50 MHz/26 ≈ 1.92 MHz SCLK.
- clk  input  1  system clock (CLK50MHZ)
- reset_n  input  1  reset; synchronous, active-low
- start  input  1  frame request; sampled only while busy=0
- channel  input  3  address sent in this frame; selects the channel converted in the *next* frame
- busy  output  1  high while a frame is in progress (state != IDLE)
- valid  output  1  one-cycle pulse; data/data_channel are updated in this cycle
- data  output  12  last conversion result; held until the next valid
- data_channel  output  3  channel that produced data
- ADC_CS_N  output  1  chip select, active-low
- ADC_SCLK  output  1  serial clock; idles high
- ADC_SADDR  output  1  serial address to the ADC (DIN)
- ADC_SDAT  input  1  serial data from the ADC (DOUT)

## Operation
- **Reset values** (reset_n=0 at a clk edge):
  - ADC_CS_N=1, ADC_SCLK=1, ADC_SADDR=0, busy=0, valid=0.
  - data=0, data_channel=0, prev_ch=0, state=IDLE.
- **States:** IDLE -> SETUP -> SHIFT -> IDLE.
- **IDLE:** start=1 latches channel into ch_q, and the state goes to SETUP.
- **SETUP:**
  - Entry: ADC_CS_N falls; ADC_SCLK stays high.
  - Duration: SCLK_DIV cycles, then go to SHIFT.
- **SHIFT:** 16 bit periods, k=0..15. Each period is SCLK_DIV cycles with SCLK low, then SCLK_DIV cycles with SCLK high.
  - ADC_SADDR update: at each falling SCLK edge, ADC_SADDR takes bit (15-k) of the control word {2'b00, ch_q, 11'b0}. ch_q therefore occupies periods 2..4.
  - ADC_SDAT sampling: registered in the clk cycle in which SCLK is driven high. No synchronizer is used; the ADC guarantees DOUT is stable well within a half-period.
  - Shift register: 16 bits, MSB first.
- **After the 16th high phase:**
  - ADC_CS_N=1 and ADC_SCLK=1; state goes to IDLE.
  - valid=1 for that single cycle.
  - data = shift[11:0]; the 4 leading zero bits are discarded and not checked.
  - data_channel = prev_ch, then prev_ch = ch_q.
- **Channel pipeline:** the first frame after reset reports data_channel=0.
- **start while busy=1:** ignored; not queued.
- **start in the valid cycle:** accepted (busy=0 in that cycle). ADC_CS_N then falls in the next cycle, giving a minimum CS_N-high time of 1 clk.
- **Reset mid-frame:** all outputs return to reset values on that edge, and the frame is discarded with no valid. prev_ch=0, so the channel pipeline is re-primed.

## Timing
- Latency: start accepted at cycle 0 -> ADC_CS_N low from cycle 1 -> valid at cycle 1+33·SCLK_DIV. With the default this is 430 clk.
- busy rises at cycle 1 and falls in the valid cycle.
- SCLK duty cycle is exactly 50 %. The CS_N-to-first-falling-edge delay is SCLK_DIV cycles.
- Maximum back-to-back throughput is one frame per 33·SCLK_DIV+1 cycles.

## Configuration
- ADC_SCAN_EN, macro not defined: request-driven operation as described above.
- ADC_SCAN_EN defined:
  - start and channel are ignored.
  - After reset the block free-runs: a new frame starts in every valid cycle, and the first frame starts 1 cycle after reset release.
  - ch_q is set to (prev_ch+1) mod 8 for each frame, so data_channel cycles 0,1,…,7,0 with one valid per frame.
  - busy is 1 except in the valid cycle. The port list is unchanged.

## Structure
- **Package adc_pkg:**
  - state enum (IDLE, SETUP, SHIFT);
  - FRAME_BITS=16, DATA_BITS=12, CH_BITS=3, ADDR_MSB_POS=13.
- **Sub-module adc_sclk_gen:**
  - half-period counter with enable, producing fall_tick/rise_tick pulses;
  - parameter SCLK_DIV; reset_n synchronous active-low.
  - The bit counter and FSM stay in adc_serial_reader.

## Test plan
- **Reset:** hold reset_n=0 for 5 cycles -> ADC_CS_N=1, ADC_SCLK=1, busy=0, valid=0, data=0.
- **Single frame:** channel=3 and start pulse, with the ADC model returning 0xA5C for ch0 -> valid at cycle 430, data=0xA5C, data_channel=0. ADC_SADDR must be 0,1,1 at SCLK rising edges 3..5, and there must be exactly 16 SCLK rising edges while CS_N is low.
- **Channel pipeline:** back-to-back frames with channel 5 then 2 -> the second valid reports data_channel=3 (from the previous test) and the ADC model's ch3 value.
- **Busy:** start held high for 1000 cycles -> exactly 2 frames, each with CS_N high for exactly 1 cycle between frames.
- **Reset mid-frame:** drop reset_n after the 7th SCLK rising edge -> CS_N=1 on the next edge, no valid; the next frame reports data_channel=0.
- **ADC_SCAN_EN:** run 9 frames -> data_channel sequence 0,1,2,3,4,5,6,7,0, each matching the model's per-channel value.
